chinx_ext_pipe: RTL and testbench
=================================

// Module: chinx_ext_pipe
// PURPOSE
//   Parametrised, pipelined immediate-extension unit for the chinx decode path.
//   Replaces the fixed 8/16-bit sign extenders with one block offering a runtime field size
//   and extension mode: zero-ext, sign-ext, upper-immediate shift and branch-offset.
//   Has a 1-cycle valid/ready stage with a one-entry skid buffer, so it sits between
//   decode and operand-select without breaking the backpressure timing path.
// PARAMETERS
//   IN_W     16  immediate input width; IN_W >= 16
//   OUT_W    32  result width; OUT_W >= IN_W + 2
//   UPPER_SH 16  left-shift amount for mode 2'b10; UPPER_SH < OUT_W
// PORTS
//   clk_i        in   1      clock; all state updates on rising edge
//   rst_i        in   1      asynchronous, active-high reset
//   flush_i      in   1      synchronous flush; drops all held results
//   in_valid_i   in   1      input beat valid
//   in_ready_o   out  1      unit can accept an input this cycle
//   imm_i        in   IN_W   raw immediate
//   size_i       in   2      field size: 00 = imm_i[7:0], 01 = imm_i[15:0], 1x = imm_i[IN_W-1:0]
//   mode_i       in   2      00 zext, 01 sext, 10 zext<<UPPER_SH, 11 sext<<2
//   out_valid_o  out  1      result valid
//   out_ready_i  in   1      consumer accepts result
//   imm_o        out  OUT_W  extended result
// BEHAVIOUR
//   - Field extraction: F = the selected low bits of imm_i; its MSB is the sign bit s.
//   - zext: fill the upper bits with 0. sext: fill the upper bits with s. Extend to OUT_W.
//   - Mode 10: zext(F) << UPPER_SH. Mode 11: sext(F) << 2. Bits shifted past OUT_W-1 are
//     discarded; vacated low bits are 0.
//   - Input handshake: a beat is accepted when in_valid_i && in_ready_o.
//     Output handshake: a beat completes when out_valid_o && out_ready_i.
//   - Storage: one output register (OR) drives imm_o/out_valid_o, plus one skid register (SK).
//   - in_ready_o = !SK.valid. It is registered state, with no combinational path from
//     out_ready_i.
//   - Accept while OR is empty or completing: the result loads OR the next edge (latency 1).
//   - Accept while OR is valid and not completing: the result loads SK.
//   - OR completes while SK is valid: SK moves to OR and SK clears. in_ready_o is already 0,
//     so no accept can happen that cycle.
//   - Throughput is 1 beat/cycle when out_ready_i stays high. Order is strictly preserved.
//   - Holding: while out_valid_o=1 && out_ready_i=0, imm_o is stable.
//     in_valid_i may drop without a beat being lost.
//   - Flush: on the next edge OR.valid=0 and SK.valid=0; any beat presented that cycle is
//     dropped. Flush has priority over all moves. in_ready_o=1 the cycle after a flush.
//   - Reset (async, any time, including mid-transfer):
//     out_valid_o=0, imm_o=0, SK cleared, in_ready_o=1.
//     No output beat appears until a new input is accepted after reset deasserts.
//   - Data registers do not load when their valid is being cleared; imm_o holds its last
//     value when out_valid_o=0.
// TESTING
//   - size=00, mode=01, imm=16'h0080 -> imm_o=32'hFFFF_FF80 one cycle after accept.
//   - size=01, mode=00, imm=16'h8000 -> 32'h0000_8000.
//     Same input with mode=01 -> 32'hFFFF_8000.
//   - size=01, mode=10, imm=16'h1234 -> 32'h1234_0000.
//     size=01, mode=11, imm=16'hFFFF -> 32'hFFFF_FFFC.
//   - out_ready_i=0, send A, B, C back-to-back:
//     -> A held in OR, B in SK, in_ready_o=0 at C. Raise out_ready_i -> A, B, C out in order,
//     with no loss or duplication.
//   - OR and SK full, assert flush_i 1 cycle -> next cycle out_valid_o=0 and in_ready_o=1.
//     A new beat then yields its result 1 cycle after accept.
//   - Assert rst_i asynchronously mid-stream (between edges) -> out_valid_o=0,
//     imm_o=32'h0, in_ready_o=1 immediately. Random valid/ready soak against a reference model.

Source files
------------

// File: rtl/chinx_ext_pipe.sv
// chinx_ext_pipe
//   Pipelined immediate-extension unit for the chinx decode path. It takes a raw
//   immediate, selects a field size (8, 16 or IN_W bits) and extends it to OUT_W
//   bits by zero-extension, sign-extension, an upper-immediate shift or a branch
//   offset (sign-extend then shift left by 2). There is one output register and a
//   one-entry skid buffer, so in_ready_o depends only on registered state.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush; drops the output and skid entries
//   in_valid_i   input beat valid
//   in_ready_o   unit can accept an input this cycle
//   imm_i        raw immediate [IN_W-1:0]
//   size_i       00 = imm_i[7:0], 01 = imm_i[15:0], 1x = imm_i[IN_W-1:0]
//   mode_i       00 zext, 01 sext, 10 zext << UPPER_SH, 11 sext << 2
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   imm_o        extended result [OUT_W-1:0]
module chinx_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int UPPER_SH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       size_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] imm_o
);

    // Field selection and extension. The sign bit is the MSB of the selected field.
    function automatic logic [OUT_W-1:0] ext_imm(input logic [IN_W-1:0] imm,
                                                 input logic [1:0]      size,
                                                 input logic [1:0]      mode);
        logic        [OUT_W-1:0] zx;
        logic signed [OUT_W-1:0] sx;
        case (size)
            2'b00: begin
                zx = {{(OUT_W-8){1'b0}}, imm[7:0]};
                sx = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            end
            2'b01: begin
                zx = {{(OUT_W-16){1'b0}}, imm[15:0]};
                sx = {{(OUT_W-16){imm[15]}}, imm[15:0]};
            end
            default: begin
                zx = {{(OUT_W-IN_W){1'b0}}, imm};
                sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            end
        endcase
        case (mode)
            2'b00:   ext_imm = zx;
            2'b01:   ext_imm = sx;
            2'b10:   ext_imm = zx << UPPER_SH;
            default: ext_imm = sx << 2;
        endcase
    endfunction

    logic             or_vld_q, or_vld_d;
    logic [OUT_W-1:0] or_dat_q, or_dat_d;
    logic             sk_vld_q, sk_vld_d;
    logic [OUT_W-1:0] sk_dat_q, sk_dat_d;
    logic [OUT_W-1:0] ext_res;
    logic             or_fire;
    logic             accept;

    assign ext_res = ext_imm(imm_i, size_i, mode_i);
    assign or_fire = or_vld_q && out_ready_i;
    // in_ready_o is registered state only, so accept never depends on out_ready_i.
    assign accept  = in_valid_i && !sk_vld_q;

    always_comb begin
        or_vld_d = or_vld_q;
        or_dat_d = or_dat_q;
        sk_vld_d = sk_vld_q;
        sk_dat_d = sk_dat_q;
        if (flush_i) begin
            // Data registers keep their contents; only the valids drop.
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (sk_vld_q) begin
            // Skid full: no accept possible; drain SK into OR when OR completes.
            if (or_fire) begin
                or_dat_d = sk_dat_q;
                sk_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!or_vld_q || or_fire) begin
                or_vld_d = 1'b1;
                or_dat_d = ext_res;
            end else begin
                sk_vld_d = 1'b1;
                sk_dat_d = ext_res;
            end
        end else if (or_fire) begin
            or_vld_d = 1'b0;
        end
    end

    // Stage boundary: output and skid control state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            or_vld_q <= 1'b0;
            or_dat_q <= '0;
            sk_vld_q <= 1'b0;
        end else begin
            or_vld_q <= or_vld_d;
            or_dat_q <= or_dat_d;
            sk_vld_q <= sk_vld_d;
        end
    end

    // Skid data is only observed through sk_vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        sk_dat_q <= sk_dat_d;
    end

    assign in_ready_o  = !sk_vld_q;
    assign out_valid_o = or_vld_q;
    assign imm_o       = or_dat_q;

endmodule

// File: tb/tb_chinx_ext_pipe.sv
module tb_chinx_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm;
    logic [1:0]       size;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] imm_out;

    int total = 0;
    int bad   = 0;

    chinx_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .UPPER_SH(16)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .imm_i(imm), .size_i(size), .mode_i(mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .imm_o(imm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference extension using masks on a 64-bit value.
    function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] sz,
                                            input logic [1:0] md);
        logic [63:0] mask, f, r;
        int w;
        w    = (sz == 2'b00) ? 8 : 16;
        mask = (64'd1 << w) - 64'd1;
        f    = {48'd0, v} & mask;
        if (md[0] && f[w-1]) r = f | ~mask;
        else r = f;
        if (md == 2'b10) r = r << 16;
        if (md == 2'b11) r = r << 2;
        return r[31:0];
    endfunction

    typedef struct {
        logic [1:0]  sz;
        logic [1:0]  md;
        logic [15:0] v;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9] = '{
        '{2'b00, 2'b01, 16'h0080, 32'hFFFF_FF80},
        '{2'b01, 2'b00, 16'h8000, 32'h0000_8000},
        '{2'b01, 2'b01, 16'h8000, 32'hFFFF_8000},
        '{2'b01, 2'b10, 16'h1234, 32'h1234_0000},
        '{2'b01, 2'b11, 16'hFFFF, 32'hFFFF_FFFC},
        '{2'b00, 2'b00, 16'h12FF, 32'h0000_00FF},
        '{2'b00, 2'b11, 16'h0080, 32'hFFFF_FE00},
        '{2'b00, 2'b10, 16'h00AB, 32'h00AB_0000},
        '{2'b10, 2'b01, 16'h7FFF, 32'h0000_7FFF}
    };

    task automatic drive(input logic [1:0] sz, input logic [1:0] md, input logic [15:0] v);
        in_valid = 1'b1;
        size     = sz;
        mode     = md;
        imm      = v;
    endtask

    logic [31:0] q[$];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm = '0; size = '0; mode = '0;
        step(); step();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_imm", {32'd0, imm_out}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        step();
        chk("idle_valid", {63'd0, out_valid}, 64'd0);

        // Back-to-back beats at full throughput, latency 1.
        foreach (vecs[i]) begin
            drive(vecs[i].sz, vecs[i].md, vecs[i].v);
            step();
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_imm", i), {32'd0, imm_out}, {32'd0, vecs[i].exp});
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_hold", {32'd0, imm_out}, 64'h0000_7FFF);

        // Backpressure: A in OR, B in SK, C waits.
        out_ready = 1'b0;
        drive(2'b01, 2'b00, 16'h000A);
        step();
        chk("bp_a_imm", {32'd0, imm_out}, 64'h0000_000A);
        chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
        drive(2'b01, 2'b00, 16'h000B);
        step();
        chk("bp_b_hold", {32'd0, imm_out}, 64'h0000_000A);
        chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
        drive(2'b01, 2'b00, 16'h000C);
        step();
        chk("bp_c_hold", {32'd0, imm_out}, 64'h0000_000A);
        chk("bp_c_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", {32'd0, imm_out}, 64'h0000_000B);
        chk("bp_out_b_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("bp_out_c", {32'd0, imm_out}, 64'h0000_000C);
        chk("bp_out_c_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_end_valid", {63'd0, out_valid}, 64'd0);

        // Flush with OR and SK full and a beat presented.
        out_ready = 1'b0;
        drive(2'b01, 2'b00, 16'h0011);
        step();
        drive(2'b01, 2'b00, 16'h0022);
        step();
        drive(2'b01, 2'b00, 16'h0033);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_hold", {32'd0, imm_out}, 64'h0000_0011);
        step();
        chk("fl_stay", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        drive(2'b01, 2'b01, 16'h8044);
        step();
        chk("fl_new_valid", {63'd0, out_valid}, 64'd1);
        chk("fl_new_imm", {32'd0, imm_out}, 64'hFFFF_8044);
        in_valid = 1'b0;
        step();

        // Asynchronous reset between edges with both entries full.
        out_ready = 1'b0;
        drive(2'b01, 2'b00, 16'h0055);
        step();
        drive(2'b01, 2'b00, 16'h0066);
        step();
        in_valid = 1'b0;
        chk("ar_pre_ready", {63'd0, in_ready}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_imm", {32'd0, imm_out}, 64'd0);
        chk("ar_ready", {63'd0, in_ready}, 64'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step(); step();
        chk("ar_no_beat", {63'd0, out_valid}, 64'd0);

        // Random valid/ready soak against a queue model.
        for (int c = 0; c < 400; c++) begin
            logic acc;
            logic fire;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            imm       = 16'($urandom);
            size      = 2'($urandom);
            mode      = 2'($urandom);
            chk("sk_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
            chk("sk_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
            if (q.size() > 0) chk("sk_imm", {32'd0, imm_out}, {32'd0, q[0]});
            fire = (q.size() > 0) && out_ready;
            acc  = in_valid && (q.size() < 2);
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(ref_ext(imm, size, mode));
            step();
        end
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
